dcm_rate_decoder: RTL and testbench
===================================

// Module: dcm_rate_decoder
// PURPOSE
// - Decoder side of the dcm programmable divider: observes a divided clock (dcm clk_2), measures its
//   half-period in clk cycles and recovers the 3-bit prog code that produced it.
// - Sits in the system clk domain next to dcm; feeds display/status logic and self-check of the prog path.
// PARAMETERS
// - BASE      5000000  nominal half-period of code 0 in clk cycles; code k nominal = BASE*M[k],
//                      M = {1,2,4,10,16,32,64,128} for k = 0..7
// - TOL_SHIFT 4        accept window for code k: |interval - BASE*M[k]| <= (BASE*M[k]) >> TOL_SHIFT
// - LOCK_CNT  3        consecutive matching intervals required to assert locked (1..15)
// PORTS
// - clk       input   1   system clock
// - rst       input   1   reset, asynchronous, active-high
// - clk_in    input   1   divided clock under test, asynchronous to clk
// - clear     input   1   sync pulse; clears timeout and unmatched
// - prog_out  output  3   decoded prog code, valid while locked=1, holds last locked value otherwise
// - locked    output  1   LOCK_CNT consecutive intervals matched the same code
// - timeout   output  1   sticky: no clk_in edge for BASE*256 clk cycles
// - unmatched output  1   sticky: an interval fell outside every window
// - interval  output  32  last measured half-period (clk cycles)
// BEHAVIOUR
// - Reset: prog_out=0, locked=0, timeout=0, unmatched=0, interval=0, state=S_WAIT, counters=0.
// - clk_in passes a 2-FF synchronizer; edge = s2 ^ s3 (both polarities counted; 1 edge = 1 half-period).
// - cnt: 32-bit, +1 every clk, saturates at 2^32-1; on edge: interval <= cnt+1, cnt <= 0.
// - Width: products BASE*M[k] and windows are computed at elaboration with 32-bit constants.
// - Classification: registered 1 cycle after edge; first code k whose window contains interval,
//   else "none".
// - Latency: clk_in transition -> locked/prog_out update = 5 clk cycles (2 sync, 1 edge, 1 latch,
//   1 classify).
// - FSM S_WAIT: no reference edge yet; first edge starts counting, interval discarded -> S_ACQ.
// - FSM S_ACQ: on each classified interval: code==cand -> match+1, else cand<=code, match<=1;
//   "none" -> match<=0, unmatched<=1. match==LOCK_CNT -> S_LOCK, locked<=1, prog_out<=cand.
// - FSM S_LOCK: interval matches prog_out -> stay; other code -> locked<=0, cand<=code, match<=1,
//   S_ACQ; none -> locked<=0, unmatched<=1, match<=0, S_ACQ.
// - Timeout: cnt reaches BASE*256 in any state -> timeout<=1, locked<=0, S_WAIT; next edge
//   interval discarded.
// - Simultaneous clear and new unmatched/timeout event: set wins.
// - prog_out never changes while locked=0.
// - rst mid-operation: immediate return to reset values, any partial interval lost.
// CONFIGURATION
// - DCM_DEC_CHANGE_EN defined: extra output changed (1 bit), one-cycle pulse when locked rises,
//   locked falls, or prog_out takes a different value; reset 0.
// - DCM_DEC_CHANGE_EN undefined: no changed port, no related logic; all other behaviour identical.
// TESTING (BASE=100, TOL_SHIFT=4, LOCK_CNT=3)
// - Toggle clk_in every 1000 clk -> 4th edge: interval=1000; locked=1, prog_out=3 after 5 cycles.
// - Locked on 3, then toggle every 100 -> locked=0 after first 100 interval; relock prog_out=0
//   after 3 more.
// - Intervals 1300 (between windows of 3 and 4) -> unmatched=1, locked=0; clear pulse -> unmatched=0.
// - Stop toggling while locked on 3 -> 25600 cycles after last edge timeout=1, locked=0,
//   prog_out stays 3.
// - Interval 1062 accepted as code 3, 1063 rejected; 12800 locks code 7.
// - Assert rst mid-lock -> all outputs 0 same cycle; macro build: changed pulses exactly once per
//   lock/unlock/code change.

Source files
------------

// File: rtl/dcm_rate_decoder_if.sv
// Signal bundle between the dcm divided-clock side and dcm_rate_decoder.
// The changed strobe exists only when DCM_DEC_CHANGE_EN is defined.
interface dcm_rate_decoder_if;
  logic        clk_in;
  logic        clear;
  logic [2:0]  prog_out;
  logic        locked;
  logic        timeout;
  logic        unmatched;
  logic [31:0] interval;
`ifdef DCM_DEC_CHANGE_EN
  logic        changed;

  modport master (
    output clk_in, clear,
    input  prog_out, locked, timeout, unmatched, interval, changed
  );
  modport slave (
    input  clk_in, clear,
    output prog_out, locked, timeout, unmatched, interval, changed
  );
`else
  modport master (
    output clk_in, clear,
    input  prog_out, locked, timeout, unmatched, interval
  );
  modport slave (
    input  clk_in, clear,
    output prog_out, locked, timeout, unmatched, interval
  );
`endif
endinterface

// File: rtl/dcm_rate_decoder.sv
// Recovers the dcm prog code from the half-period of the divided clock clk_in.
// Optional feature macro DCM_DEC_CHANGE_EN adds the one-cycle changed strobe.
module dcm_rate_decoder #(
  parameter int unsigned BASE      = 5000000,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned LOCK_CNT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  dcm_rate_decoder_if.slave dec
);

  localparam logic [31:0] TIMEOUT_CYC = 32'(BASE) * 32'd256;
  localparam logic [3:0]  LOCK_N      = 4'(LOCK_CNT);

  function automatic logic [31:0] nominal(input int k);
    logic [31:0] m;
    case (k)
      0:       m = 32'd1;
      1:       m = 32'd2;
      2:       m = 32'd4;
      3:       m = 32'd10;
      4:       m = 32'd16;
      5:       m = 32'd32;
      6:       m = 32'd64;
      default: m = 32'd128;
    endcase
    return 32'(BASE) * m;
  endfunction

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t      r_state, w_state_n;
  logic        r_s1, r_s2, r_s3;
  logic        w_edge;
  logic        w_tmo_hit;
  logic [31:0] r_cnt;
  logic [31:0] r_interval;
  logic        r_iv_valid;

  logic [31:0] w_lo [8];
  logic [31:0] w_hi [8];
  logic [2:0]  w_code;
  logic        w_hit;
  logic        r_cls_valid;
  logic        r_cls_hit;
  logic [2:0]  r_cls_code;

  logic [2:0]  r_cand,      w_cand_n;
  logic [3:0]  r_match,     w_match_n;
  logic [2:0]  r_prog,      w_prog_n;
  logic        r_locked,    w_locked_n;
  logic        r_timeout,   w_timeout_n;
  logic        r_unmatched, w_unmatched_n;

  // Both clk_in polarities count: one detected edge closes one half-period.
  assign w_edge    = r_s2 ^ r_s3;
  assign w_tmo_hit = !w_edge && (r_cnt == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_cnt      <= '0;
      r_interval <= '0;
      r_iv_valid <= 1'b0;
    end else begin
      r_s1       <= dec.clk_in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_iv_valid <= w_edge && (r_state != S_WAIT);
      if (w_edge) begin
        r_cnt      <= '0;
        r_interval <= (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
      end else if (r_cnt != 32'hFFFF_FFFF) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_win
    localparam logic [31:0] NOM = nominal(g);
    localparam logic [31:0] TOL = NOM >> TOL_SHIFT;
    assign w_lo[g] = NOM - TOL;
    assign w_hi[g] = NOM + TOL;
  end

  // Scan from the top so the lowest matching code wins on overlap.
  always_comb begin
    w_code = '0;
    w_hit  = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (r_interval >= w_lo[k] && r_interval <= w_hi[k]) begin
        w_hit  = 1'b1;
        w_code = 3'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cls_valid <= 1'b0;
      r_cls_hit   <= 1'b0;
      r_cls_code  <= '0;
    end else begin
      r_cls_valid <= r_iv_valid;
      r_cls_hit   <= w_hit;
      r_cls_code  <= w_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_cand      <= '0;
      r_match     <= '0;
      r_prog      <= '0;
      r_locked    <= 1'b0;
      r_timeout   <= 1'b0;
      r_unmatched <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cand      <= w_cand_n;
      r_match     <= w_match_n;
      r_prog      <= w_prog_n;
      r_locked    <= w_locked_n;
      r_timeout   <= w_timeout_n;
      r_unmatched <= w_unmatched_n;
    end
  end

  // clear is applied first so a coincident unmatched/timeout event overrides it.
  always_comb begin
    w_state_n     = r_state;
    w_cand_n      = r_cand;
    w_match_n     = r_match;
    w_prog_n      = r_prog;
    w_locked_n    = r_locked;
    w_timeout_n   = r_timeout;
    w_unmatched_n = r_unmatched;

    if (dec.clear) begin
      w_timeout_n   = 1'b0;
      w_unmatched_n = 1'b0;
    end

    if (w_tmo_hit) begin
      w_state_n   = S_WAIT;
      w_timeout_n = 1'b1;
      w_locked_n  = 1'b0;
      w_match_n   = '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_edge) w_state_n = S_ACQ;
        end
        S_ACQ: begin
          if (r_cls_valid) begin
            if (!r_cls_hit) begin
              w_match_n     = '0;
              w_unmatched_n = 1'b1;
            end else begin
              if (r_cls_code == r_cand) begin
                w_match_n = r_match + 4'd1;
              end else begin
                w_cand_n  = r_cls_code;
                w_match_n = 4'd1;
              end
              if (w_match_n >= LOCK_N) begin
                w_state_n  = S_LOCK;
                w_locked_n = 1'b1;
                w_prog_n   = w_cand_n;
              end
            end
          end
        end
        S_LOCK: begin
          if (r_cls_valid) begin
            if (!r_cls_hit) begin
              w_state_n     = S_ACQ;
              w_locked_n    = 1'b0;
              w_unmatched_n = 1'b1;
              w_match_n     = '0;
            end else if (r_cls_code != r_prog) begin
              w_state_n  = S_ACQ;
              w_locked_n = 1'b0;
              w_cand_n   = r_cls_code;
              w_match_n  = 4'd1;
            end
          end
        end
        default: w_state_n = S_WAIT;
      endcase
    end
  end

`ifdef DCM_DEC_CHANGE_EN
  logic r_changed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_changed <= 1'b0;
    else     r_changed <= (w_locked_n != r_locked) || (w_prog_n != r_prog);
  end

  assign dec.changed = r_changed;
`endif

  assign dec.prog_out  = r_prog;
  assign dec.locked    = r_locked;
  assign dec.timeout   = r_timeout;
  assign dec.unmatched = r_unmatched;
  assign dec.interval  = r_interval;

endmodule

// File: tb/tb_dcm_rate_decoder.sv
// Bench for dcm_rate_decoder (BASE=100): directed and random half-periods
// against a run-length model of code recognition.
module tb_dcm_rate_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  dcm_rate_decoder_if dif ();

  dcm_rate_decoder #(.BASE(100), .TOL_SHIFT(4), .LOCK_CNT(3)) dut (
    .clk (clk),
    .rst (rst),
    .dec (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  bit          m_ref;
  int          m_run;
  int          m_code;
  bit          m_locked;
  int          m_prog;
  bit          m_unm;
  bit          m_tmo;
  int          m_gap;
  bit          m_disc;
  int          m_chg;

`ifdef DCM_DEC_CHANGE_EN
  int chg_seen = 0;
  always @(negedge clk) if (!rst && dif.changed === 1'b1) chg_seen++;
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int classify(input int unsigned iv);
    int unsigned mult [8];
    int unsigned nom;
    int unsigned tol;
    mult = '{1, 2, 4, 10, 16, 32, 64, 128};
    for (int k = 0; k < 8; k++) begin
      nom = 100 * mult[k];
      tol = nom >> 4;
      if (iv + tol >= nom && iv <= nom + tol) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ref = 0; m_run = 0; m_code = 0; m_locked = 0; m_prog = 0;
    m_unm = 0; m_tmo = 0; m_gap = 0; m_disc = 1;
  endtask

  // Locked means the trailing run of identical recognised codes is long enough.
  task automatic model_edge();
    int  c;
    bit  old_l;
    int  old_p;
    old_l = m_locked;
    old_p = m_prog;
    if (!m_ref) begin
      m_ref  = 1;
      m_disc = 1;
    end else begin
      m_disc = 0;
      c = classify(m_gap);
      if (c < 0) begin
        m_run = 0;
        m_unm = 1;
      end else if (m_run > 0 && c == m_code) begin
        m_run++;
      end else begin
        m_code = c;
        m_run  = 1;
      end
      m_locked = (m_run >= 3);
      if (m_locked) m_prog = m_code;
    end
    if (m_locked != old_l || m_prog != old_p) m_chg++;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_locked"},    dif.locked,    32'(m_locked));
    chk({tag, "_prog"},      dif.prog_out,  32'(m_prog));
    chk({tag, "_unmatched"}, dif.unmatched, 32'(m_unm));
    chk({tag, "_timeout"},   dif.timeout,   32'(m_tmo));
  endtask

  // Toggle clk_in now, check 4 and 5 cycles later, leave n cycles until the next toggle.
  task automatic tog(input int n);
    bit old_l;
    old_l = m_locked;
    dif.clk_in = ~dif.clk_in;
    model_edge();
    repeat (4) @(posedge clk);
    #1;
    chk("lat4_locked", dif.locked, 32'(old_l));
    @(posedge clk);
    #1;
    chk_all("edge");
    if (!m_disc) chk("interval", dif.interval, 32'(m_gap));
    if (n > 5) begin
      repeat (n - 5) @(posedge clk);
      #1;
    end
    m_gap = n;
  endtask

  task automatic do_clear();
    dif.clear = 1'b1;
    @(posedge clk);
    #1;
    dif.clear = 1'b0;
    m_unm = 0;
    m_tmo = 0;
    m_gap += 1;
    chk("clear_unmatched", dif.unmatched, 32'd0);
    chk("clear_timeout",   dif.timeout,   32'd0);
  endtask

  initial begin
    int unsigned mult [4];
    int code, nom, tol, reps;
    checks = 0;
    failures = 0;
    m_chg = 0;
    mult = '{1, 2, 4, 10};
    rst = 1'b1;
    dif.clk_in = 1'b0;
    dif.clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_prog",     dif.prog_out,  32'd0);
    chk("rst_locked",   dif.locked,    32'd0);
    chk("rst_timeout",  dif.timeout,   32'd0);
    chk("rst_unmatch",  dif.unmatched, 32'd0);
    chk("rst_interval", dif.interval,  32'd0);

    // 1000-cycle half-periods lock code 3 on the 4th edge
    repeat (4) tog(1000);
    chk("lock3_locked", dif.locked,   32'd1);
    chk("lock3_prog",   dif.prog_out, 32'd3);

    // switch to 100: unlock on first, relock on code 0
    repeat (4) tog(100);
    chk("relock0_locked", dif.locked,   32'd1);
    chk("relock0_prog",   dif.prog_out, 32'd0);

    // 1300 falls between windows
    repeat (2) tog(1300);
    tog(5);
    chk("gap_unmatched", dif.unmatched, 32'd1);
    chk("gap_locked",    dif.locked,    32'd0);
    do_clear();

    // random half-periods around the windows of codes 0..3
    for (int g = 0; g < 10; g++) begin
      code = $urandom_range(0, 3);
      nom  = 100 * mult[code];
      tol  = nom >> 4;
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) tog(nom - tol - 2 + $urandom_range(0, 2 * tol + 4));
    end

    // upper window edge 1062 accepted, then timeout while locked
    repeat (4) tog(1062);
    tog(5);
    chk("w1062_locked", dif.locked,   32'd1);
    chk("w1062_prog",   dif.prog_out, 32'd3);
    repeat (25595) @(posedge clk);
    #1;
    chk("tmo_early", dif.timeout, 32'd0);
    chk("tmo_early_locked", dif.locked, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    if (m_locked) m_chg++;
    m_tmo = 1; m_locked = 0; m_run = 0; m_ref = 0;
    chk_all("tmo");
    chk("tmo_prog_hold", dif.prog_out, 32'd3);
    do_clear();

    // 1063 rejected
    tog(1063);
    tog(5);
    chk("w1063_unmatched", dif.unmatched, 32'd1);

    // 12800 locks code 7
    repeat (3) tog(12800);
    tog(5);
    chk("lock7_locked", dif.locked,   32'd1);
    chk("lock7_prog",   dif.prog_out, 32'd7);

`ifdef DCM_DEC_CHANGE_EN
    repeat (3) @(posedge clk);
    #1;
    chk("changed_count", 32'(chg_seen), 32'(m_chg));
`endif

    // asynchronous reset mid-lock
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_prog",     dif.prog_out,  32'd0);
    chk("arst_locked",   dif.locked,    32'd0);
    chk("arst_timeout",  dif.timeout,   32'd0);
    chk("arst_unmatch",  dif.unmatched, 32'd0);
    chk("arst_interval", dif.interval,  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
